// File: rtl/alu_pkg.sv
// Shared opcode, state and error-bit definitions for the sequential ALU.
package alu_pkg;

  localparam int unsigned OP_AND   = 0;
  localparam int unsigned OP_OR    = 1;
  localparam int unsigned OP_ADD   = 2;
  localparam int unsigned OP_SUB   = 3;
  localparam int unsigned OP_PASSB = 4;
  localparam int unsigned OP_XOR   = 5;
  localparam int unsigned OP_MUL   = 6;
  localparam int unsigned OP_DIV   = 7;
  localparam int unsigned OP_REM   = 8;

  localparam int unsigned ERR_W       = 2;
  localparam int unsigned ERR_DIV0    = 0;
  localparam int unsigned ERR_ILLEGAL = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    IT_MUL = 2'd0,
    IT_DIV = 2'd1,
    IT_REM = 2'd2
  } iter_op_e;

endpackage

// File: rtl/alu_muldiv_iter.sv
// Bit-serial shift-add multiplier and restoring divider, one bit per cycle.
// The start cycle already performs the first step, so WIDTH steps end WIDTH cycles after start.
module alu_muldiv_iter
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  iter_op_e         op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             high_nz
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  logic             running;
  logic [CNT_W-1:0] cnt;
  iter_op_e         op_q;
  logic [WIDTH-1:0] b_q;
  // hi holds the product upper half or the partial remainder; lo the product lower half or quotient
  logic [WIDTH-1:0] hi, lo;

  logic [WIDTH-1:0] src_hi, src_lo, src_b, nxt_hi, nxt_lo;
  iter_op_e         src_op;
  logic [WIDTH:0]   add_sum, shifted;

  always_comb begin
    src_hi  = start ? '0 : hi;
    src_lo  = start ? a : lo;
    src_b   = start ? b : b_q;
    src_op  = start ? op : op_q;
    add_sum = {1'b0, src_hi} + (src_lo[0] ? {1'b0, src_b} : '0);
    shifted = {src_hi, src_lo[WIDTH-1]};
    nxt_hi  = src_hi;
    nxt_lo  = src_lo;
    if (src_op == IT_MUL) begin
      {nxt_hi, nxt_lo} = {add_sum, src_lo[WIDTH-1:1]};
    end else if (shifted >= {1'b0, src_b}) begin
      nxt_hi = WIDTH'(shifted - {1'b0, src_b});
      nxt_lo = {src_lo[WIDTH-2:0], 1'b1};
    end else begin
      nxt_hi = shifted[WIDTH-1:0];
      nxt_lo = {src_lo[WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      running <= 1'b0;
      cnt     <= '0;
      op_q    <= IT_MUL;
      b_q     <= '0;
      hi      <= '0;
      lo      <= '0;
    end else if (start) begin
      running <= 1'b1;
      cnt     <= CNT_W'(WIDTH - 1);
      op_q    <= op;
      b_q     <= b;
      hi      <= nxt_hi;
      lo      <= nxt_lo;
    end else if (running) begin
      if (cnt == '0) begin
        running <= 1'b0;
      end else begin
        cnt <= cnt - 1'b1;
        hi  <= nxt_hi;
        lo  <= nxt_lo;
      end
    end
  end

  assign done    = running && (cnt == '0);
  assign result  = (op_q == IT_REM) ? hi : lo;
  assign high_nz = |hi;

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU with valid/ready handshake; logic/add ops finish in one cycle,
// MUL/DIV/REM run through the bit-serial iterator.
module alu_seq
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH  = 64,
  parameter int unsigned MODE_W = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [MODE_W-1:0] mode,
  input  logic [WIDTH-1:0]  A,
  input  logic [WIDTH-1:0]  B,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out,
  output logic              zeroflag,
  output logic              carry,
  output logic              ovf,
  output logic [ERR_W-1:0]  err
);

  state_e state, nxt_state;

  logic             accept, is_iter, iter_start, iter_done, iter_high_nz, mul_q;
  iter_op_e         iter_op;
  logic [WIDTH-1:0] res, iter_result;
  logic             res_c, res_v;
  logic [ERR_W-1:0] res_err;
  logic [WIDTH:0]   sum, diff;

  assign accept     = in_valid && in_ready;
  assign iter_start = accept && is_iter;

  // Opcode decode and single-cycle result
  always_comb begin
    sum     = {1'b0, A} + {1'b0, B};
    diff    = {1'b0, A} - {1'b0, B};
    is_iter = 1'b0;
    iter_op = IT_MUL;
    res     = '0;
    res_c   = 1'b0;
    res_v   = 1'b0;
    res_err = '0;
    case (mode)
      MODE_W'(OP_AND):   res = A & B;
      MODE_W'(OP_OR):    res = A | B;
      MODE_W'(OP_XOR):   res = A ^ B;
      MODE_W'(OP_PASSB): res = B;
      MODE_W'(OP_ADD): begin
        res   = sum[WIDTH-1:0];
        res_c = sum[WIDTH];
        res_v = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
      end
      MODE_W'(OP_SUB): begin
        res   = diff[WIDTH-1:0];
        res_c = diff[WIDTH];
        res_v = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
      end
      MODE_W'(OP_MUL): begin
        is_iter = 1'b1;
        iter_op = IT_MUL;
      end
      MODE_W'(OP_DIV): begin
        if (B == '0) begin
          res               = '1;
          res_err[ERR_DIV0] = 1'b1;
        end else begin
          is_iter = 1'b1;
          iter_op = IT_DIV;
        end
      end
      MODE_W'(OP_REM): begin
        if (B == '0) begin
          res               = A;
          res_err[ERR_DIV0] = 1'b1;
        end else begin
          is_iter = 1'b1;
          iter_op = IT_REM;
        end
      end
      default: res_err[ERR_ILLEGAL] = 1'b1;
    endcase
  end

  alu_muldiv_iter #(.WIDTH(WIDTH)) u_iter (
    .clk    (CLK),
    .rst    (RST),
    .start  (iter_start),
    .op     (iter_op),
    .a      (A),
    .b      (B),
    .done   (iter_done),
    .result (iter_result),
    .high_nz(iter_high_nz)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= ST_IDLE;
    else     state <= nxt_state;
  end

  always_comb begin
    nxt_state = state;
    case (state)
      ST_IDLE: if (accept)    nxt_state = is_iter ? ST_BUSY : ST_DONE;
      ST_BUSY: if (iter_done) nxt_state = ST_DONE;
      ST_DONE: if (out_ready) nxt_state = ST_IDLE;
      default:                nxt_state = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == ST_IDLE);
    out_valid = (state == ST_DONE);
  end

  // Result and flags are loaded only on completion, so they hold throughout DONE
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      out      <= '0;
      zeroflag <= 1'b0;
      carry    <= 1'b0;
      ovf      <= 1'b0;
      err      <= '0;
      mul_q    <= 1'b0;
    end else if (accept && !is_iter) begin
      out      <= res;
      zeroflag <= (res == '0);
      carry    <= res_c;
      ovf      <= res_v;
      err      <= res_err;
    end else if (iter_start) begin
      mul_q <= (iter_op == IT_MUL);
    end else if ((state == ST_BUSY) && iter_done) begin
      out      <= iter_result;
      zeroflag <= (iter_result == '0);
      carry    <= 1'b0;
      ovf      <= mul_q && iter_high_nz;
      err      <= '0;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed vector bench for alu_seq at WIDTH=8 and WIDTH=64.
module tb_alu_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic       iv8, ir8, ov8, ordy8, zf8, c8, v8;
  logic [3:0] m8;
  logic [7:0] a8, b8, o8;
  logic [1:0] e8;

  logic        iv64, ir64, ov64, ordy64, zf64, c64, v64;
  logic [3:0]  m64;
  logic [63:0] a64, b64, o64;
  logic [1:0]  e64;

  alu_seq #(.WIDTH(8), .MODE_W(4)) u8 (
    .CLK(clk), .RST(rst), .in_valid(iv8), .in_ready(ir8), .mode(m8), .A(a8), .B(b8),
    .out_valid(ov8), .out_ready(ordy8), .out(o8), .zeroflag(zf8), .carry(c8), .ovf(v8), .err(e8)
  );

  alu_seq #(.WIDTH(64), .MODE_W(4)) u64 (
    .CLK(clk), .RST(rst), .in_valid(iv64), .in_ready(ir64), .mode(m64), .A(a64), .B(b64),
    .out_valid(ov64), .out_ready(ordy64), .out(o64), .zeroflag(zf64), .carry(c64), .ovf(v64), .err(e64)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0] mode;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] out;
    logic       zf;
    logic       c;
    logic       v;
    logic [1:0] err;
    int         lat;
  } vec_t;

  vec_t vecs[20];

  // Offer one op at the current negedge, scramble inputs after accept, count cycles to out_valid
  task automatic run8(input logic [3:0] m, input logic [7:0] a, input logic [7:0] b, output int lat);
    int guard = 0;
    while (!ir8 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    iv8 = 1'b1; m8 = m; a8 = a; b8 = b;
    @(negedge clk);
    iv8 = 1'b0; m8 = 4'd4; a8 = ~a; b8 = ~b;
    lat = 1;
    while (!ov8 && lat < 200) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic consume8(input string name);
    ordy8 = 1'b1;
    @(negedge clk);
    ordy8 = 1'b0;
    check({name, " out_valid drop"}, 64'(ov8), 64'd0);
    check({name, " in_ready back"}, 64'(ir8), 64'd1);
  endtask

  task automatic run64(input logic [3:0] m, input logic [63:0] a, input logic [63:0] b, output int lat);
    iv64 = 1'b1; m64 = m; a64 = a; b64 = b;
    @(negedge clk);
    iv64 = 1'b0; a64 = ~a; b64 = ~b;
    lat = 1;
    while (!ov64 && lat < 200) begin
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    int lat;
    int seen;
    rst = 1'b1;
    iv8 = 1'b0; ordy8 = 1'b0; m8 = '0; a8 = '0; b8 = '0;
    iv64 = 1'b0; ordy64 = 1'b0; m64 = '0; a64 = '0; b64 = '0;

    vecs[0]  = '{4'd0,  8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1'b0, 2'b00, 1};
    vecs[1]  = '{4'd1,  8'hF0, 8'h0F, 8'hFF, 1'b0, 1'b0, 1'b0, 2'b00, 1};
    vecs[2]  = '{4'd2,  8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 1'b0, 2'b00, 1};
    vecs[3]  = '{4'd2,  8'h7F, 8'h01, 8'h80, 1'b0, 1'b0, 1'b1, 2'b00, 1};
    vecs[4]  = '{4'd3,  8'h80, 8'h01, 8'h7F, 1'b0, 1'b0, 1'b1, 2'b00, 1};
    vecs[5]  = '{4'd3,  8'h07, 8'h07, 8'h00, 1'b1, 1'b0, 1'b0, 2'b00, 1};
    vecs[6]  = '{4'd3,  8'h03, 8'h05, 8'hFE, 1'b0, 1'b1, 1'b0, 2'b00, 1};
    vecs[7]  = '{4'd4,  8'h12, 8'h34, 8'h34, 1'b0, 1'b0, 1'b0, 2'b00, 1};
    vecs[8]  = '{4'd5,  8'hAA, 8'hFF, 8'h55, 1'b0, 1'b0, 1'b0, 2'b00, 1};
    vecs[9]  = '{4'd6,  8'd15, 8'd17, 8'd255, 1'b0, 1'b0, 1'b0, 2'b00, 9};
    vecs[10] = '{4'd6,  8'd16, 8'd16, 8'd0,  1'b1, 1'b0, 1'b1, 2'b00, 9};
    vecs[11] = '{4'd6,  8'hFF, 8'hFF, 8'h01, 1'b0, 1'b0, 1'b1, 2'b00, 9};
    vecs[12] = '{4'd7,  8'd100, 8'd7, 8'd14, 1'b0, 1'b0, 1'b0, 2'b00, 9};
    vecs[13] = '{4'd8,  8'd100, 8'd7, 8'd2,  1'b0, 1'b0, 1'b0, 2'b00, 9};
    vecs[14] = '{4'd7,  8'd9,  8'd0, 8'hFF,  1'b0, 1'b0, 1'b0, 2'b01, 1};
    vecs[15] = '{4'd8,  8'd9,  8'd0, 8'd9,   1'b0, 1'b0, 1'b0, 2'b01, 1};
    vecs[16] = '{4'd12, 8'd5,  8'd5, 8'd0,   1'b1, 1'b0, 1'b0, 2'b10, 1};
    vecs[17] = '{4'd7,  8'hFF, 8'h01, 8'hFF, 1'b0, 1'b0, 1'b0, 2'b00, 9};
    vecs[18] = '{4'd8,  8'hFE, 8'hFF, 8'hFE, 1'b0, 1'b0, 1'b0, 2'b00, 9};
    vecs[19] = '{4'd7,  8'd5,  8'd200, 8'd0, 1'b1, 1'b0, 1'b0, 2'b00, 9};

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("rst out", 64'(o8), 64'd0);
    check("rst out_valid", 64'(ov8), 64'd0);
    check("rst flags", 64'({zf8, c8, v8, e8}), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rst in_ready", 64'(ir8), 64'd1);

    // Table-driven WIDTH=8 vectors
    for (int i = 0; i < 20; i++) begin
      run8(vecs[i].mode, vecs[i].a, vecs[i].b, lat);
      check($sformatf("v%0d out", i), 64'(o8), 64'(vecs[i].out));
      check($sformatf("v%0d zeroflag", i), 64'(zf8), 64'(vecs[i].zf));
      check($sformatf("v%0d carry", i), 64'(c8), 64'(vecs[i].c));
      check($sformatf("v%0d ovf", i), 64'(v8), 64'(vecs[i].v));
      check($sformatf("v%0d err", i), 64'(e8), 64'(vecs[i].err));
      check($sformatf("v%0d latency", i), 64'(lat), 64'(vecs[i].lat));
      consume8($sformatf("v%0d", i));
    end

    // WIDTH=64 checks
    run64(4'd2, 64'd5, 64'd3, lat);
    check("w64 add out", o64, 64'd8);
    check("w64 add zf/c", 64'({zf64, c64}), 64'd0);
    check("w64 add latency", 64'(lat), 64'd1);
    ordy64 = 1'b1; @(negedge clk); ordy64 = 1'b0;
    run64(4'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, lat);
    check("w64 add wrap out", o64, 64'd0);
    check("w64 add wrap zf/c", 64'({zf64, c64}), 64'b11);
    ordy64 = 1'b1; @(negedge clk); ordy64 = 1'b0;
    run64(4'd6, 64'h1_0000_0000, 64'h1_0000_0000, lat);
    check("w64 mul out", o64, 64'd0);
    check("w64 mul ovf", 64'(v64), 64'd1);
    check("w64 mul latency", 64'(lat), 64'd65);
    ordy64 = 1'b1; @(negedge clk); ordy64 = 1'b0;

    // Result held while out_ready stays low; new offers ignored
    run8(4'd2, 8'h7F, 8'h01, lat);
    iv8 = 1'b1; m8 = 4'd3; a8 = 8'h00; b8 = 8'h00;
    for (int k = 0; k < 5; k++) begin
      check($sformatf("hold%0d out", k), 64'(o8), 64'h80);
      check($sformatf("hold%0d flags", k), 64'({zf8, c8, v8, e8}), 64'b00100);
      check($sformatf("hold%0d valid/ready", k), 64'({ov8, ir8}), 64'b10);
      @(negedge clk);
    end
    iv8 = 1'b0;
    check("hold after out", 64'(o8), 64'h80);
    consume8("hold");

    // Reset three cycles into a DIV discards it
    iv8 = 1'b1; m8 = 4'd7; a8 = 8'd200; b8 = 8'd3;
    @(negedge clk);
    iv8 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst out_valid", 64'(ov8), 64'd0);
    check("midrst out", 64'(o8), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (ov8) seen++;
    end
    check("midrst no result", 64'(seen), 64'd0);
    run8(4'd2, 8'd1, 8'd1, lat);
    check("post-rst add out", 64'(o8), 64'd2);
    check("post-rst add latency", 64'(lat), 64'd1);
    consume8("post-rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
